// File: rtl/ps2_keyboard_if.sv
// Consumer-side byte stream of the PS/2 keyboard receiver.
// The receiver drives data/valid as master; the CPU port or keyboard
// controller returns ready as slave.
interface ps2_keyboard_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the raw PS2_CLK and
// PS2_DAT pins, decodes 11-bit device-to-host frames, and queues good
// scan-code bytes in a small FIFO drained over a valid/ready handshake.
// The PS/2 lines are only ever sampled, never driven.
// Optional feature macro: PS2_PARITY_CHECK_EN. When it is defined, frames with
// bad odd parity are rejected. When it is undefined, only the stop bit is
// checked.
module ps2_keyboard #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 50000,
  parameter int FIFO_AW = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           ps2_clk,
  input  logic           ps2_dat,
  ps2_keyboard_if.master bus,
  output logic           err,
  output logic           overflow,
  input  logic           ovf_clr
);

  localparam int FCW   = $clog2(FILTER + 1);
  localparam int TCW   = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [1:0]       clk_sync, dat_sync;
  logic             clk_filt, dat_filt;
  logic [FCW-1:0]   clk_cnt, dat_cnt;
  logic             fall;

  state_t           state;
  logic [3:0]       bit_cnt;
  logic [9:0]       shreg;
  logic [TCW-1:0]   to_cnt;
  logic             frame_ok;
  logic             push_req;

  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, rd_next;
  logic [7:0]       data_q;
  logic             empty, full, pop, push_ok;

  // Two-flop synchronizers bring the asynchronous pins into the clock domain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Glitch filters: a line only changes after FILTER equal samples; the clock
  // filter also raises a one-cycle strobe when its level goes high to low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      dat_filt <= 1'b1;
      clk_cnt  <= '0;
      dat_cnt  <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= clk_filt && !clk_sync[1] && (clk_cnt == FCW'(FILTER - 1));
      if (clk_sync[1] == clk_filt) begin
        clk_cnt <= '0;
      end else if (clk_cnt == FCW'(FILTER - 1)) begin
        clk_filt <= clk_sync[1];
        clk_cnt  <= '0;
      end else begin
        clk_cnt <= clk_cnt + FCW'(1);
      end
      if (dat_sync[1] == dat_filt) begin
        dat_cnt <= '0;
      end else if (dat_cnt == FCW'(FILTER - 1)) begin
        dat_filt <= dat_sync[1];
        dat_cnt  <= '0;
      end else begin
        dat_cnt <= dat_cnt + FCW'(1);
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = shreg[9] && (^shreg[8:0]);
`else
  assign frame_ok = shreg[9];
`endif

  assign push_req = (state == CHECK) && frame_ok;

  // Frame decoder: start bit, then 8 data + parity + stop shifted in LSB
  // first, one CHECK cycle, and an abort if the PS/2 clock stalls mid-frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      to_cnt  <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall && !dat_filt) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (fall) begin
            shreg  <= {dat_filt, shreg[9:1]};
            to_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              state <= CHECK;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (to_cnt == TCW'(TIMEOUT)) begin
            state  <= IDLE;
            to_cnt <= '0;
            err    <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TCW'(1);
          end
        end
        CHECK: begin
          err   <= !frame_ok;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign pop     = !empty && bus.ready;
  assign push_ok = push_req && (!full || pop);
  assign rd_next = rd_ptr + (FIFO_AW + 1)'(pop);

  // FIFO storage; a full FIFO only accepts a byte if a pop frees a slot.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= shreg[7:0];
    end
  end

  // Pointers, head-byte register and sticky overflow flag; the head register
  // bypasses the incoming byte when it lands in an otherwise empty FIFO.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_q   <= 8'h00;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + (FIFO_AW + 1)'(push_ok);
      rd_ptr <= rd_next;
      if (push_ok && (rd_next == wr_ptr)) begin
        data_q <= shreg[7:0];
      end else if (rd_next != wr_ptr) begin
        data_q <= mem[rd_next[FIFO_AW-1:0]];
      end
      if (push_req && full && !pop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.valid = !empty;
  assign bus.data  = data_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: drives PS/2 frames onto the pins and
// compares the byte stream, err pulses and overflow flag against a queue model.
module tb_ps2_keyboard;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 50000;
  localparam int FIFO_AW = 3;
  localparam int DEPTH   = 8;
  localparam int HALF    = 40;
  localparam int GAP     = 60;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  logic ovf_clr = 1'b0;
  logic err;
  logic overflow;

  ps2_keyboard_if kbd_bus();

  ps2_keyboard #(.FILTER(FILTER), .TIMEOUT(TIMEOUT), .FIFO_AW(FIFO_AW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .bus      (kbd_bus),
    .err      (err),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clock = ~clock;

  logic [7:0] expQ[$];
  logic [7:0] poppedLog[$];
  logic       expOverflow = 1'b0;
  int         errExp = 0;
  int         errSeen = 0;
  int         compared = 0;
  int         mismatched = 0;
  logic       errPrev = 1'b0;
  logic       randReady = 1'b0;
  int         cycleCount = 0;
  int         lastFall = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Odd parity bit: makes the total count of ones in data+parity odd.
  function automatic logic oddPar(input logic [7:0] b);
    return ~(^b);
  endfunction

  // Reference decision for a complete frame, applied at the stop-bit edge.
  task automatic modelFrame(input logic [7:0] b, input logic par, input logic stop);
    logic good;
`ifdef PS2_PARITY_CHECK_EN
    good = stop && (^{par, b});
`else
    good = stop;
`endif
    if (!good) errExp++;
    else if (expQ.size() == DEPTH) expOverflow = 1'b1;
    else expQ.push_back(b);
  endtask

  // Drives the first nbits of a frame (start, data LSB first, parity, stop).
  task automatic applyStimulus(input logic [7:0] b, input logic par, input logic stop,
                               input int nbits, input bit glitch);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (glitch) begin
        waitCycles(HALF / 2);
        ps2_clk = 1'b0;
        waitCycles(1);
        ps2_clk = 1'b1;
        waitCycles(HALF - HALF / 2 - 1);
      end else begin
        waitCycles(HALF);
      end
      ps2_clk = 1'b0;
      lastFall = cycleCount;
      if (i == 10) modelFrame(b, par, stop);
      waitCycles(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    waitCycles(GAP);
  endtask

  task automatic checkpoint(input string tag);
    checkOutput({tag, "_err_count"}, errSeen, errExp);
    checkOutput({tag, "_overflow"}, overflow, expOverflow);
    checkOutput({tag, "_valid"}, kbd_bus.valid, expQ.size() != 0);
  endtask

  initial begin
    int errBefore;
    bit found;
    int lat;
    logic [7:0] rb;
    logic rp, rs;

    kbd_bus.ready = 1'b1;

    fork
      forever begin
        @(posedge clock);
        cycleCount++;
        #1;
        if (randReady) kbd_bus.ready = 1'($urandom_range(0, 1));
      end
      forever begin
        @(negedge clock);
        if (reset_n) begin
          if (err) begin
            errSeen++;
            checkOutput("err_single_cycle", errPrev, 1'b0);
          end
          errPrev = err;
          if (kbd_bus.valid) begin
            if (expQ.size() == 0) begin
              checkOutput("valid_vs_model", kbd_bus.valid, 1'b0);
            end else begin
              checkOutput("data_head", kbd_bus.data, expQ[0]);
              if (kbd_bus.ready) begin
                poppedLog.push_back(kbd_bus.data);
                void'(expQ.pop_front());
              end
            end
          end
        end else begin
          errPrev = 1'b0;
        end
      end
    join_none

    // Reset state
    waitCycles(5);
    checkOutput("reset_valid", kbd_bus.valid, 1'b0);
    checkOutput("reset_err", err, 1'b0);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_data", kbd_bus.data, 8'h00);
    reset_n = 1'b1;
    waitCycles(5);

    // Good 0x1C frame
    applyStimulus(8'h1C, 1'b0, 1'b1, 11, 0);
    checkpoint("good1c");
    checkOutput("good1c_count", poppedLog.size(), 1);
    if (poppedLog.size() > 0) checkOutput("good1c_byte", poppedLog[0], 8'h1C);
    checkOutput("good1c_err_lit", errSeen, 0);
    poppedLog.delete();

    // 0x1C with wrong parity
    applyStimulus(8'h1C, 1'b1, 1'b1, 11, 0);
    checkpoint("badpar");
`ifdef PS2_PARITY_CHECK_EN
    checkOutput("badpar_count", poppedLog.size(), 0);
    checkOutput("badpar_err_lit", errSeen, 1);
`else
    checkOutput("badpar_count", poppedLog.size(), 1);
    if (poppedLog.size() > 0) checkOutput("badpar_byte", poppedLog[0], 8'h1C);
    checkOutput("badpar_err_lit", errSeen, 0);
`endif
    poppedLog.delete();

    // Overflow: 9 frames with the consumer stalled
    kbd_bus.ready = 1'b0;
    for (int k = 1; k <= 9; k++) applyStimulus(8'(k), oddPar(8'(k)), 1'b1, 11, 0);
    checkpoint("ovf");
    checkOutput("ovf_flag_lit", overflow, 1'b1);
    kbd_bus.ready = 1'b1;
    waitCycles(20);
    checkOutput("ovf_drain_count", poppedLog.size(), 8);
    for (int i = 0; i < poppedLog.size() && i < 8; i++)
      checkOutput("ovf_drain_byte", poppedLog[i], 32'(i + 1));
    checkOutput("ovf_drain_valid", kbd_bus.valid, 1'b0);
    ovf_clr = 1'b1;
    waitCycles(1);
    ovf_clr = 1'b0;
    expOverflow = 1'b0;
    waitCycles(2);
    checkOutput("ovf_clr", overflow, 1'b0);
    poppedLog.delete();

    // Timeout on a stalled partial frame, then a good 0xF0
    errBefore = errSeen;
    applyStimulus(8'h0A, 1'b0, 1'b1, 5, 0);
    errExp++;
    found = 0;
    for (int i = 0; i < TIMEOUT + 500; i++) begin
      waitCycles(1);
      if (errSeen > errBefore) begin
        found = 1;
        break;
      end
    end
    lat = cycleCount - lastFall;
    checkOutput("timeout_err_seen", found, 1'b1);
    checkOutput("timeout_latency_ok", (lat >= TIMEOUT) && (lat <= TIMEOUT + 40), 1'b1);
    waitCycles(5);
    applyStimulus(8'hF0, 1'b1, 1'b1, 11, 0);
    checkpoint("after_to");
    checkOutput("after_to_count", poppedLog.size(), 1);
    if (poppedLog.size() > 0) checkOutput("after_to_byte", poppedLog[0], 8'hF0);
    poppedLog.delete();

    // Glitches on ps2_clk between real edges
    applyStimulus(8'h5A, 1'b1, 1'b1, 11, 1);
    checkpoint("glitch");
    checkOutput("glitch_count", poppedLog.size(), 1);
    if (poppedLog.size() > 0) checkOutput("glitch_byte", poppedLog[0], 8'h5A);
    poppedLog.delete();

    // Reset in the middle of a frame with a byte still queued
    kbd_bus.ready = 1'b0;
    applyStimulus(8'h33, oddPar(8'h33), 1'b1, 11, 0);
    checkOutput("prereset_valid", kbd_bus.valid, 1'b1);
    errBefore = errSeen;
    applyStimulus(8'h29, 1'b0, 1'b1, 6, 0);
    reset_n = 1'b0;
    waitCycles(3);
    expQ.delete();
    reset_n = 1'b1;
    waitCycles(5);
    checkOutput("midreset_valid", kbd_bus.valid, 1'b0);
    kbd_bus.ready = 1'b1;
    applyStimulus(8'h29, 1'b0, 1'b1, 11, 0);
    checkpoint("postreset");
    checkOutput("postreset_no_err", errSeen, errBefore);
    checkOutput("postreset_count", poppedLog.size(), 1);
    if (poppedLog.size() > 0) checkOutput("postreset_byte", poppedLog[0], 8'h29);
    poppedLog.delete();

    // Randomized frames with a randomly stalling consumer
    randReady = 1'b1;
    for (int n = 0; n < 14; n++) begin
      rb = 8'($urandom);
      rp = oddPar(rb) ^ ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 5) != 0);
      applyStimulus(rb, rp, rs, 11, bit'($urandom_range(0, 1)));
      checkpoint("rand");
    end
    randReady = 1'b0;
    waitCycles(2);
    kbd_bus.ready = 1'b1;
    waitCycles(20);
    checkpoint("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
